// File: rtl/sobel_stage_sequencer.sv
// rtl/sobel_stage_sequencer.sv - ap_ctrl_hs sequencer for the Sobel sub-pipeline stages
//
// Runs NUM_STAGES child stages strictly in index order, driving each child's
// ap_start and waiting for its ap_done, while presenting an ap_ctrl_hs slave
// interface to the host. Per-stage and whole-run cycle counts are kept in
// saturating registers. An optional watchdog aborts a stage that hangs.
//
// Ports:
//   ap_clk, ap_rst_n        clock, synchronous active-low reset
//   ap_start                host start request (sampled in IDLE only)
//   ap_done, ap_ready       one-cycle pulses at the end of a run or abort
//   ap_idle                 high while the sequencer is in IDLE
//   stage_start             one-hot (or zero) ap_start to the children
//   stage_ready/stage_done  ap_ready / ap_done from the children
//   lat_sel, lat_data       per-stage latency readout
//   total_cycles            cycle count of the whole last run
//   err_timeout, err_stage  watchdog abort flag and offending stage index

module sobel_stage_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 0,
    localparam int IDX_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_ready,
    input  logic [NUM_STAGES-1:0] stage_done,
    input  logic [IDX_W-1:0]      lat_sel,
    output logic [CNT_W-1:0]      lat_data,
    output logic [CNT_W-1:0]      total_cycles,
    output logic                  err_timeout,
    output logic [IDX_W-1:0]      err_stage
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_t;

    localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] ONE_HOT0 = NUM_STAGES'(1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             started;
    logic [CNT_W-1:0] stage_cnt [NUM_STAGES];

    logic cur_ready;
    logic cur_done;
    logic wd_hit;

    // Only the active child's handshake matters; other indices are ignored.
    assign cur_ready = stage_ready[idx];
    assign cur_done  = stage_done[idx];

    // Compared against the count before this cycle's increment, so the stage
    // has already been granted TIMEOUT full cycles when the watchdog fires.
    assign wd_hit = (TIMEOUT > 0) && (stage_cnt[idx] == CNT_W'(TIMEOUT));

    assign ap_idle  = (state == S_IDLE);
    assign lat_data = stage_cnt[lat_sel];

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state        <= S_IDLE;
            idx          <= '0;
            started      <= 1'b0;
            stage_start  <= '0;
            ap_done      <= 1'b0;
            ap_ready     <= 1'b0;
            total_cycles <= '0;
            err_timeout  <= 1'b0;
            err_stage    <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage_cnt[i] <= '0;
            end
        end else begin
            ap_done  <= 1'b0;
            ap_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            stage_cnt[i] <= '0;
                        end
                        total_cycles <= '0;
                        err_timeout  <= 1'b0;
                        err_stage    <= '0;
                        idx          <= '0;
                        started      <= 1'b0;
                        stage_start  <= ONE_HOT0;
                        state        <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (total_cycles != CNT_MAX) begin
                        total_cycles <= total_cycles + 1'b1;
                    end
                    if (stage_cnt[idx] != CNT_MAX) begin
                        stage_cnt[idx] <= stage_cnt[idx] + 1'b1;
                    end

                    if (cur_done) begin
                        // Completion wins over the watchdog and counts as an
                        // implied ready if none was seen.
                        if (idx == LAST_IDX) begin
                            stage_start <= '0;
                            ap_done     <= 1'b1;
                            ap_ready    <= 1'b1;
                            state       <= S_FINISH;
                        end else begin
                            idx         <= idx + IDX_W'(1);
                            started     <= 1'b0;
                            stage_start <= ONE_HOT0 << (idx + IDX_W'(1));
                        end
                    end else if (wd_hit) begin
                        err_timeout <= 1'b1;
                        err_stage   <= idx;
                        stage_start <= '0;
                        ap_done     <= 1'b1;
                        ap_ready    <= 1'b1;
                        state       <= S_FINISH;
                    end else begin
                        if (cur_ready) begin
                            started <= 1'b1;
                        end
                        stage_start <= (started || cur_ready) ? '0 : (ONE_HOT0 << idx);
                    end
                end

                S_FINISH: begin
                    if (total_cycles != CNT_MAX) begin
                        total_cycles <= total_cycles + 1'b1;
                    end
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_stage_sequencer.sv
// tb/tb_sobel_stage_sequencer.sv - self-checking bench for sobel_stage_sequencer

module tb_sobel_stage_sequencer;

    localparam int TO = 10;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_done;
    logic        ap_ready;
    logic        ap_idle;
    logic [3:0]  stage_start;
    logic [3:0]  stage_ready = '0;
    logic [3:0]  stage_done = '0;
    logic [1:0]  lat_sel = '0;
    logic [31:0] lat_data;
    logic [31:0] total_cycles;
    logic        err_timeout;
    logic [1:0]  err_stage;

    sobel_stage_sequencer #(
        .NUM_STAGES(4),
        .CNT_W     (32),
        .TIMEOUT   (TO)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ap_start    (ap_start),
        .ap_done     (ap_done),
        .ap_ready    (ap_ready),
        .ap_idle     (ap_idle),
        .stage_start (stage_start),
        .stage_ready (stage_ready),
        .stage_done  (stage_done),
        .lat_sel     (lat_sel),
        .lat_data    (lat_data),
        .total_cycles(total_cycles),
        .err_timeout (err_timeout),
        .err_stage   (err_stage)
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    logic [3:0] exp_ss   [0:63];
    bit         exp_dn   [0:63];
    bit         exp_idle [0:63];
    int         t0 = 0;
    int         chk_end = 0;
    bit         chk_on = 1'b0;

    int s_rdy [4];
    int s_dn  [4];
    int ecnt  [4];
    int etot;
    bit eerr;
    int estg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Per-cycle comparison against the expected timeline.
    always @(negedge ap_clk) begin : cmp
        int rel;
        if (chk_on) begin
            rel = cyc - t0;
            if (rel >= 0 && rel <= chk_end) begin
                check("stage_start", 32'(stage_start), 32'(exp_ss[rel]));
                check("ap_done", 32'(ap_done), 32'(exp_dn[rel]));
                check("ap_ready", 32'(ap_ready), 32'(exp_dn[rel]));
                check("ap_idle", 32'(ap_idle), 32'(exp_idle[rel]));
            end
        end
    end

    // Builds the expected timeline from per-stage ready/done cycle numbers
    // (1-based from each stage's start; 0 means never), then drives the run.
    task automatic run(input bit glitch, input int rst_rel);
        int pos;
        int kk [4];
        logic [3:0] rv, dv;
        for (int c = 0; c < 64; c++) begin
            exp_ss[c] = '0; exp_dn[c] = 1'b0; exp_idle[c] = 1'b0;
        end
        exp_idle[0] = 1'b1;
        pos = 1; eerr = 1'b0; estg = 0;
        for (int i = 0; i < 4; i++) ecnt[i] = 0;
        for (int i = 0; i < 4; i++) begin
            int len, hi;
            if (s_dn[i] == 0) begin
                len = TO + 1; hi = len; eerr = 1'b1; estg = i;
            end else begin
                len = s_dn[i];
                hi = (s_rdy[i] > 0 && s_rdy[i] < s_dn[i]) ? s_rdy[i] : len;
            end
            for (int k = 0; k < len; k++) if (k < hi) exp_ss[pos + k][i] = 1'b1;
            ecnt[i] = len;
            pos += len;
            if (eerr) break;
        end
        exp_dn[pos] = 1'b1;
        exp_idle[pos + 1] = 1'b1;
        etot = pos;
        if (rst_rel > 0) begin
            for (int c = rst_rel + 1; c < 64; c++) begin
                exp_ss[c] = '0; exp_dn[c] = 1'b0; exp_idle[c] = 1'b1;
            end
            for (int i = 0; i < 4; i++) ecnt[i] = 0;
            etot = 0; eerr = 1'b0; estg = 0;
            chk_end = rst_rel + 2;
        end else begin
            chk_end = pos + 1;
        end

        for (int i = 0; i < 4; i++) kk[i] = 0;
        @(posedge ap_clk); #1;
        t0 = cyc;
        chk_on = 1'b1;
        for (int rel = 0; rel <= chk_end; rel++) begin
            ap_start = (rel == 0) || (glitch && rel == 5);
            ap_rst_n = !(rst_rel > 0 && rel == rst_rel);
            rv = '0; dv = '0;
            for (int i = 0; i < 4; i++) begin
                if (kk[i] == 0 && stage_start[i]) kk[i] = 1;
                else if (kk[i] > 0) kk[i]++;
                if (kk[i] > 0 && kk[i] == s_rdy[i]) rv[i] = 1'b1;
                if (kk[i] > 0 && kk[i] == s_dn[i]) dv[i] = 1'b1;
            end
            if (glitch && rel == 2) dv[3] = 1'b1;
            stage_ready = rv;
            stage_done = dv;
            @(posedge ap_clk); #1;
        end
        chk_on = 1'b0;
        ap_start = 1'b0; ap_rst_n = 1'b1; stage_ready = '0; stage_done = '0;
        for (int i = 0; i < 4; i++) begin
            lat_sel = 2'(i); #1;
            check($sformatf("lat_data[%0d]", i), lat_data, 32'(ecnt[i]));
        end
        check("total_cycles", total_cycles, 32'(etot));
        check("err_timeout", 32'(err_timeout), 32'(eerr));
        check("err_stage", 32'(err_stage), 32'(estg));
        repeat (2) @(posedge ap_clk);
    endtask

    initial begin
        ap_rst_n = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        check("rst_idle", 32'(ap_idle), 32'd1);
        check("rst_stage_start", 32'(stage_start), 32'd0);
        check("rst_done", 32'(ap_done), 32'd0);
        check("rst_ready", 32'(ap_ready), 32'd0);
        check("rst_total", total_cycles, 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_lat0", lat_data, 32'd0);

        // Nominal.
        s_rdy = '{3, 3, 3, 3}; s_dn = '{3, 3, 3, 3};
        run(1'b0, 0);
        check("nominal_total_lit", total_cycles, 32'd13);

        // Pipelined child on stage 2.
        s_rdy = '{3, 3, 2, 3}; s_dn = '{3, 3, 7, 3};
        run(1'b0, 0);
        lat_sel = 2'd2; #1;
        check("pipe_lat2_lit", lat_data, 32'd7);

        // Done without ready on stage 1.
        s_rdy = '{3, 0, 3, 3}; s_dn = '{3, 4, 3, 3};
        run(1'b0, 0);
        lat_sel = 2'd1; #1;
        check("noready_lat1_lit", lat_data, 32'd4);

        // Watchdog: stage 1 hangs.
        s_rdy = '{2, 0, 3, 3}; s_dn = '{2, 0, 3, 3};
        run(1'b0, 0);
        lat_sel = 2'd1; #1;
        check("wd_lat1_lit", lat_data, 32'd11);
        check("wd_total_lit", total_cycles, 32'd14);
        check("wd_err_lit", 32'(err_timeout), 32'd1);
        check("wd_stage_lit", 32'(err_stage), 32'd1);

        // Ignored events: stray ap_start and stage_done[3].
        s_rdy = '{3, 3, 3, 3}; s_dn = '{3, 3, 3, 3};
        run(1'b1, 0);
        check("ignored_total_lit", total_cycles, 32'd13);

        // Reset during stage 2, then a clean run.
        run(1'b0, 8);
        run(1'b0, 0);
        check("post_reset_total_lit", total_cycles, 32'd13);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sobel_stage_sequencer.md
# sobel_stage_sequencer

Synthesizable ap_ctrl_hs sequencer that drives the start/ready/done handshake of the Sobel kernel's sub-pipelines (init fill, line-buffer load, convolution, write-back) in strict order, acting as the initiating end of the handshake that the simulation dataflow monitors only observe. It presents an ap_ctrl_hs slave interface to the host, runs each child stage to completion, and records per-stage and total cycle counts so that latency is visible in hardware, not just in simulation CSV dumps. It has an optional per-stage watchdog that aborts a hung stage.

## Interface
- NUM_STAGES, 4, number of child stages, sequenced in index order 0..NUM_STAGES-1
- CNT_W, 32, width of each latency counter
- TIMEOUT, 0, per-stage watchdog limit in cycles; 0 disables the watchdog

Ports:
- ap_clk  in  1  single clock; all logic on rising edge
- ap_rst_n  in  1  reset, synchronous and active-low
- ap_start  in  1  host start request
- ap_done  out  1  one-cycle pulse when the run completes or aborts
- ap_ready  out  1  one-cycle pulse, coincident with ap_done
- ap_idle  out  1  high only in IDLE
- stage_start  out  NUM_STAGES  ap_start to each child; at most one bit high
- stage_ready  in  NUM_STAGES  ap_ready from each child
- stage_done  in  NUM_STAGES  ap_done (ap_done_int) from each child
- lat_sel  in  clog2(NUM_STAGES)  stage index for latency readout
- lat_data  out  CNT_W  cycle count of the selected stage (combinational mux of registers)
- total_cycles  out  CNT_W  cycle count of the whole last run
- err_timeout  out  1  sticky: the last run was aborted by the watchdog
- err_stage  out  clog2(NUM_STAGES)  index of the stage that timed out

## Operation
- States: IDLE, RUN, FINISH. Register idx holds the active stage. Flag started records that stage_ready was seen for the active stage.
- IDLE: ap_idle=1. If ap_start=1, the sequencer:
  - clears all stage counters, total_cycles, err_timeout and err_stage;
  - sets idx=0 and goes to RUN.
- RUN: stage_start[idx]=1 while started=0.
  - stage_ready[idx]=1 sets started; stage_start[idx] drops on the next cycle.
  - stage_done[idx]=1 (whether started=0 or 1, and including the cycle ready is seen) completes the stage. A completion with no ready seen first is taken as an implied ready.
  - After completion, if idx<NUM_STAGES-1: idx++, started=0, stay in RUN. Otherwise go to FINISH.
- FINISH: lasts one cycle with ap_done=1, ap_ready=1, ap_idle=0, then returns to IDLE.
- Stage counter[idx] increments every RUN cycle in which idx is active, including the completing cycle. Counters saturate at all-ones.
- total_cycles increments on every RUN and FINISH cycle, and also saturates.
- Watchdog (TIMEOUT>0): if counter[idx]==TIMEOUT and stage_done[idx]=0 in the same cycle:
  - set err_timeout=1 and err_stage=idx;
  - drop stage_start;
  - go to FINISH. The remaining stages are skipped.
- ap_start while not in IDLE is ignored, with no queuing.
- stage_ready and stage_done on non-active indices are ignored.
- Counters, err_timeout and err_stage hold their values in IDLE until the next accepted ap_start.

## Timing
- Reset (ap_rst_n=0 at an edge) applies from any state, including mid-run:
  - state=IDLE, idx=0, started=0;
  - stage_start=0, ap_done=0, ap_ready=0;
  - all counters 0, err_timeout=0, err_stage=0;
  - ap_idle=1 from the cycle after the reset edge.
- stage_start, ap_done and ap_ready are registered.
- Cycle numbering for a run:
  - ap_start is sampled high in IDLE at cycle T.
  - stage_start[0]=1 at T+1.
  - If ready is seen at cycle R, stage_start drops at R+1.
  - If done is seen at cycle D for stage i<N-1, stage_start[i+1]=1 at D+1.
  - If done is seen for the last stage at cycle D, ap_done=ap_ready=1 at D+1, and ap_idle=1 at D+2.
- A new ap_start is accepted at D+2 at the earliest.
- Minimum run, where every child asserts ready and done in the same cycle as start: NUM_STAGES+1 cycles from T+1 to the ap_done cycle.
- A stage whose done arrives in its first start cycle gets count 1.

## Test plan
- Nominal run. Each child asserts ready+done 3 cycles after its start rises (start cycle = count 1). Required: stage_start pulses stay one-hot in order 0..3; counters 3,3,3,3; total_cycles=13; ap_done lands exactly 13 cycles after T.
- Pipelined child. Stage 2 asserts ready at its 2nd cycle and done at its 7th. Required: stage_start[2] is high for 2 cycles; counter[2]=7; stage 3 starts the cycle after done.
- Done without ready. Stage 1 asserts done at its 4th cycle with ready never asserted. Required: counter[1]=4, the sequence continues, err_timeout=0.
- Watchdog. TIMEOUT=10; stage 1 never completes. Required: stage_start[1] drops after 10 counted cycles; ap_done pulses once; err_timeout=1, err_stage=1; counters 2 and 3 stay 0.
- Ignored events. Pulse ap_start mid-run, and pulse stage_done[3] while stage 0 is active. Required: no change in sequence or counts; exactly one ap_done.
- Reset mid-run. Drive ap_rst_n=0 for 1 cycle while in stage 2. Required next cycle: all outputs at reset values and ap_idle=1. A following ap_start produces a full clean run.
